// File: rtl/neighbor_window_gen_pkg.sv
// Shared definitions for the 3x3 neighbourhood generator: FSM encoding,
// neighbour numbering with (drow,dcol) offsets, and delay-line tap layout.
package neighbor_window_gen_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int NB_TL = 1;
  localparam int NB_T  = 2;
  localparam int NB_TR = 3;
  localparam int NB_L  = 4;
  localparam int NB_R  = 5;
  localparam int NB_BL = 6;
  localparam int NB_B  = 7;
  localparam int NB_BR = 8;

  localparam int NUM_NB   = 8;
  localparam int NUM_TAPS = 9;
  localparam int TAP_CTR  = 4;

  function automatic int nb_drow(input int k);
    case (k)
      NB_TL, NB_T, NB_TR: return -1;
      NB_BL, NB_B, NB_BR: return 1;
      default:            return 0;
    endcase
  endfunction

  function automatic int nb_dcol(input int k);
    case (k)
      NB_TL, NB_L, NB_BL: return -1;
      NB_TR, NB_R, NB_BR: return 1;
      default:            return 0;
    endcase
  endfunction

  // Tap slots are ordered by ascending delay; slot 8 is the oldest (top-left).
  function automatic int nb_tap(input int k);
    return TAP_CTR - (3 * nb_drow(k) + nb_dcol(k));
  endfunction

  function automatic int tap_ofs(input int slot, input int w);
    return (slot / 3) * w + (slot % 3);
  endfunction

endpackage

// File: rtl/neighbor_window_gen_pixel_delay_line.sv
// Shift register of 2*IMG_W+3 pixels. Taps present the contents as they
// will be after this cycle's shift, so a registered window lines up with its accept.
module pixel_delay_line
  import neighbor_window_gen_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            shift_i,
  input  logic [PIX_W-1:0]                din_i,
  output logic [NUM_TAPS-1:0][PIX_W-1:0]  taps_o
);

  localparam int DEPTH = 2 * IMG_W + 3;

  logic [DEPTH-1:0][PIX_W-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (shift_i) line_d = {line_q[DEPTH-2:0], din_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_q <= '0;
    else     line_q <= line_d;
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
    assign taps_o[g] = line_d[tap_ofs(g, IMG_W)];
  end

endmodule

// File: rtl/neighbor_window_gen.sv
// Raster pixel stream -> one registered 3x3 window per pixel, with border
// masking and an end-of-frame flush so every frame yields IMG_W*IMG_H windows.
module neighbor_window_gen
  import neighbor_window_gen_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             win_valid,
  output logic             win_last,
  output logic [PIX_W-1:0] in,
  output logic [PIX_W-1:0] in_1,
  output logic [PIX_W-1:0] in_2,
  output logic [PIX_W-1:0] in_3,
  output logic [PIX_W-1:0] in_4,
  output logic [PIX_W-1:0] in_5,
  output logic [PIX_W-1:0] in_6,
  output logic [PIX_W-1:0] in_7,
  output logic [PIX_W-1:0] in_8,
  output logic             res_1,
  output logic             res_2,
  output logic             res_3,
  output logic             res_4,
  output logic             res_5,
  output logic             res_6,
  output logic             res_7,
  output logic             res_8
);

  localparam int CW = $clog2(IMG_W * IMG_H + 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(IMG_W);
  localparam logic [CW-1:0] PIX_LAST  = CW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(IMG_H - 1);

  state_e                         state_q, state_d;
  logic [CW-1:0]                  acc_q, acc_d;
  logic [CW-1:0]                  fl_q, fl_d;
  logic [CW-1:0]                  row_q, row_d, col_q, col_d;
  logic                           accept, emit, shift, last_c;
  logic [PIX_W-1:0]               din;
  logic [NUM_TAPS-1:0][PIX_W-1:0] taps;
  logic [NUM_NB-1:0]              res_c, res_q;
  logic [NUM_NB-1:0][PIX_W-1:0]   nbv_c, nb_q;
  logic [PIX_W-1:0]               ctr_q;
  logic                           wv_q, wl_q;

  assign pix_ready = ~rst & (state_q != ST_FLUSH);
  assign accept    = pix_valid & pix_ready;
  assign emit      = ((state_q == ST_RUN) & accept) | (state_q == ST_FLUSH);
  assign shift     = accept | (state_q == ST_FLUSH);
  assign din       = (state_q == ST_FLUSH) ? '0 : pix_in;
  assign last_c    = (row_q == ROW_LAST) & (col_q == COL_LAST);

  pixel_delay_line #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_line (
    .clk     (clk),
    .rst     (rst),
    .shift_i (shift),
    .din_i   (din),
    .taps_o  (taps)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fl_d    = fl_q;
    unique case (state_q)
      ST_FILL: if (accept) begin
        acc_d = acc_q + 1'b1;
        if (acc_q == FILL_LAST) state_d = ST_RUN;
      end
      ST_RUN: if (accept) begin
        acc_d = acc_q + 1'b1;
        if (acc_q == PIX_LAST) begin
          state_d = ST_FLUSH;
          acc_d   = '0;
        end
      end
      ST_FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == FILL_LAST) begin
          state_d = ST_FILL;
          fl_d    = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (emit) begin
      if (last_c) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == COL_LAST) begin
        row_d = row_q + 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Row/column bounds decide existence; the delay line wraps across rows,
  // so masked neighbours are zeroed rather than taken from the taps.
  always_comb begin
    res_c = '0;
    nbv_c = '0;
    for (int k = NB_TL; k <= NB_BR; k++) begin
      int r, c;
      r = int'(row_q) + nb_drow(k);
      c = int'(col_q) + nb_dcol(k);
      if (r >= 0 && r < IMG_H && c >= 0 && c < IMG_W) begin
        res_c[k-1] = 1'b1;
        nbv_c[k-1] = taps[nb_tap(k)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      acc_q   <= '0;
      fl_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wv_q    <= 1'b0;
      wl_q    <= 1'b0;
      ctr_q   <= '0;
      nb_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wv_q    <= emit;
      wl_q    <= emit & last_c;
      if (emit) begin
        ctr_q <= taps[TAP_CTR];
        nb_q  <= nbv_c;
        res_q <= res_c;
      end
    end
  end

  assign win_valid = wv_q;
  assign win_last  = wl_q;
  assign in        = ctr_q;
  assign in_1      = nb_q[0];
  assign in_2      = nb_q[1];
  assign in_3      = nb_q[2];
  assign in_4      = nb_q[3];
  assign in_5      = nb_q[4];
  assign in_6      = nb_q[5];
  assign in_7      = nb_q[6];
  assign in_8      = nb_q[7];
  assign res_1     = res_q[0];
  assign res_2     = res_q[1];
  assign res_3     = res_q[2];
  assign res_4     = res_q[3];
  assign res_5     = res_q[4];
  assign res_6     = res_q[5];
  assign res_7     = res_q[6];
  assign res_8     = res_q[7];

endmodule

// File: doc/neighbor_window_gen.md
Name: neighbor_window_gen

Overview:
- Converts a raster-order pixel stream into one 3x3 neighbourhood per pixel. Each neighbourhood is the centre plus 8 neighbours plus 8 "neighbour exists" flags.
- Sits directly upstream of compare_neighbor, the local-maximum comparator. Its outputs map 1:1 onto that block's in, in_1..in_8 and res_1..res_8 inputs.
- Handles image borders and end-of-frame flush, so the comparator sees exactly IMG_W*IMG_H windows per frame.

Parameters:
- PIX_W, 8, pixel width in bits
- IMG_W, 16, image width in pixels (>=3)
- IMG_H, 16, image height in rows (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pix_in  in  PIX_W  input pixel, raster order (row-major, row 0 first)
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pix_in this cycle
- win_valid  out  1  window outputs valid this cycle (single-cycle strobe per window)
- win_last  out  1  final window of the frame
- in  out  PIX_W  centre pixel (r,c)
- in_1..in_8  out  PIX_W each  neighbours: 1=(r-1,c-1), 2=(r-1,c), 3=(r-1,c+1), 4=(r,c-1), 5=(r,c+1), 6=(r+1,c-1), 7=(r+1,c), 8=(r+1,c+1)
- res_1..res_8  out  1 each  1 = neighbour k lies inside the image

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high; while asserted, all outputs are 0, all counters are 0, and state = ST_FILL.
- Accept rule: a pixel is accepted when pix_valid && pix_ready. Gaps in pix_valid stall the block; no state advances without an accept, except in ST_FLUSH.
- Delay line: 2*IMG_W+3 entries of PIX_W, shifted by one on each accept and on each flush cycle. Flush shifts in 0.
- Linear index: L = r*IMG_W + c. The window for L is complete once index L+IMG_W+1 has entered the delay line.
- FSM states:
  - ST_FILL: pix_ready=1; accept the first IMG_W+1 pixels of the frame; no windows. On the (IMG_W+1)th accept, go to ST_RUN.
  - ST_RUN: pix_ready=1; each accept emits one window next cycle, for centre L = accepted index - (IMG_W+1). On the accept of index IMG_W*IMG_H-1, go to ST_FLUSH.
  - ST_FLUSH: pix_ready=0; emits one window per cycle for the remaining IMG_W+1 centres, with no stalls. After the last one, go to ST_FILL for the next frame.
- Output timing: all window outputs are registered. win_valid is high exactly one cycle after the triggering accept or flush step; otherwise 0.
- Output hold: when win_valid=0, in/in_k/res_k hold their last values. Consumers must qualify with win_valid.
- Border handling: res_k=0 iff neighbour k has row<0, row>=IMG_H, col<0 or col>=IMG_W. When res_k=0, in_k is forced to 0. Row wrap through the delay line must never leak into in_k.
- Centre position: a centre (row,col) counter pair advances on every emitted window. col wraps at IMG_W-1 and increments row; both clear after win_last.
- win_last: 1 together with win_valid for centre (IMG_H-1, IMG_W-1) only.
- Window count: exactly IMG_W*IMG_H windows per frame, in raster order of centre.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0) of a new frame.
- Counter widths: $clog2(IMG_W*IMG_H+1). No overflow is possible by construction.

Decomposition:
- Shared package holds:
  - neighbour index constants (NB_TL=1 .. NB_BR=8) with their (drow,dcol) offsets;
  - state encoding ST_FILL/ST_RUN/ST_FLUSH.
- One sub-module, pixel_delay_line: a parameterised shift register of depth 2*IMG_W+3, with shift-enable and tap outputs at offsets 0, 1, 2, IMG_W, IMG_W+1, IMG_W+2, 2*IMG_W, 2*IMG_W+1, 2*IMG_W+2.
- FSM, position counters and border masking live in the top.

Test Plan (IMG_W=4, IMG_H=3, pixel value = L+1, pix_valid held high):
- Reset: assert rst mid-stream -> all outputs 0 immediately (asynchronous), pix_ready=1 after release, state ST_FILL. No win_valid until 5 further accepts.
- First window: accept values 1..6 -> win_valid the cycle after value 6 is accepted, with:
  - in=1, in_5=2, in_7=5, in_8=6;
  - res = 0,0,0,0,1,0,1,1; in_1..4 and in_6 = 0.
- Interior window: after value 11 is accepted -> next cycle in=6, in_1..in_8 = 1,2,3,5,7,9,10,11, all res=1.
- Flush and last: after value 12 is accepted -> pix_ready=0 for 5 cycles with win_valid=1 on each. The final one has:
  - in=12, in_1=7, in_2=8, in_4=11;
  - res = 1,1,0,1,0,0,0,0; win_last=1.
  - Total win_valid pulses in the frame = 12.
- Stalled input: insert random pix_valid gaps -> same 12 windows with identical values, each one cycle after its triggering accept.
- Back-to-back frames: two frames streamed continuously -> second frame's first window equals scenario 2. No values from frame 1 appear in any in_k where res_k=0.
